// File: rtl/ifetch.sv
// Instruction fetch: owns the fetch PC, issues word requests to imem, buffers up to
// two returned instructions and presents one per cycle to decode.
module ifetch #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h1000,
  parameter logic [31:0]     NOP      = 32'h00000013
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_fault,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            instr_valid,
  output logic            fetch_fault,
  output logic [3:0]      fault_cause
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FAULT} state_e;

  typedef struct packed {
    logic [31:0]     ins;
    logic [XLEN-1:0] epc;
    logic            flt;
    logic [3:0]      cause;
  } entry_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]      outst_q, outst_d;
  logic [1:0]      stale_q, stale_d;
  logic [XLEN-1:0] pcq_q [2];
  logic [XLEN-1:0] pcq_d [2];
  logic            pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  entry_t          buf_q [2];
  entry_t          buf_d [2];
  logic            buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [1:0]      buf_cnt_q, buf_cnt_d;
  entry_t          out_q, out_d;
  logic            out_valid_q, out_valid_d;

  logic [2:0]      credits;
  logic            acc, resp_live, misalign, push, pop;
  entry_t          resp_ent, mis_ent, bubble_ent;

  assign credits        = {1'b0, outst_q} + {1'b0, buf_cnt_q};
  assign imem_req_valid = (state_q == S_FETCH) && (credits < 3'd2);
  assign imem_req_addr  = {fetch_pc_q[XLEN-1:2], 2'b00};
  assign acc            = imem_req_valid && imem_req_ready;
  assign resp_live      = imem_resp_valid && (stale_q == 2'd0);
  assign misalign       = redirect_pc[1:0] != 2'b00;

  assign instr       = out_q.ins;
  assign pc          = out_q.epc;
  assign instr_valid = out_valid_q;
  assign fetch_fault = out_q.flt;
  assign fault_cause = out_q.cause;

  always_comb begin
    resp_ent.ins   = imem_resp_fault ? NOP : imem_resp_data;
    resp_ent.epc   = pcq_q[pcq_rd_q];
    resp_ent.flt   = imem_resp_fault;
    resp_ent.cause = imem_resp_fault ? 4'd1 : 4'd0;

    mis_ent.ins    = NOP;
    mis_ent.epc    = redirect_pc;
    mis_ent.flt    = 1'b1;
    mis_ent.cause  = 4'd0;

    bubble_ent.ins   = NOP;
    bubble_ent.epc   = out_q.epc;
    bubble_ent.flt   = 1'b0;
    bubble_ent.cause = 4'd0;
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    outst_d     = outst_q + {1'b0, acc} - {1'b0, imem_resp_valid};
    stale_d     = stale_q;
    pcq_d       = pcq_q;
    pcq_wr_d    = pcq_wr_q;
    pcq_rd_d    = pcq_rd_q;
    buf_d       = buf_q;
    buf_wr_d    = buf_wr_q;
    buf_rd_d    = buf_rd_q;
    buf_cnt_d   = buf_cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pop         = !stall && (buf_cnt_q != 2'd0);
    push        = resp_live && (stall || (buf_cnt_q != 2'd0));

    // The PC queue tracks every accepted request, stale or not, so it stays in step
    // with the in-order response stream across redirects.
    if (acc) begin
      pcq_d[pcq_wr_q] = fetch_pc_q;
      pcq_wr_d        = ~pcq_wr_q;
      fetch_pc_d      = fetch_pc_q + XLEN'(4);
    end
    if (imem_resp_valid) begin
      pcq_rd_d = ~pcq_rd_q;
      if (stale_q != 2'd0) stale_d = stale_q - 2'd1;
    end

    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (resp_live && imem_resp_fault) state_d = S_FAULT;
      S_FAULT: ;
      default: state_d = S_BOOT;
    endcase

    // Everything requested after a faulting fetch is discarded on return.
    if (resp_live && imem_resp_fault) stale_d = outst_d;

    if (push) begin
      buf_d[buf_wr_q] = resp_ent;
      buf_wr_d        = ~buf_wr_q;
    end
    if (pop) buf_rd_d = ~buf_rd_q;
    buf_cnt_d = buf_cnt_q + {1'b0, push} - {1'b0, pop};

    if (!stall) begin
      if (pop) begin
        out_d       = buf_q[buf_rd_q];
        out_valid_d = 1'b1;
      end else if (resp_live) begin
        out_d       = resp_ent;
        out_valid_d = 1'b1;
      end else begin
        out_d       = bubble_ent;
        out_valid_d = 1'b0;
      end
    end

    if (redirect_valid) begin
      stale_d     = outst_d;
      fetch_pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
      buf_wr_d    = 1'b0;
      buf_rd_d    = 1'b0;
      buf_cnt_d   = 2'd0;
      out_d       = bubble_ent;
      out_valid_d = 1'b0;
      state_d     = S_FETCH;
      if (misalign) begin
        buf_d[0]  = mis_ent;
        buf_wr_d  = 1'b1;
        buf_cnt_d = 2'd1;
        state_d   = S_FAULT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_BOOT;
      fetch_pc_q  <= RESET_PC;
      outst_q     <= '0;
      stale_q     <= '0;
      pcq_q       <= '{default: '0};
      pcq_wr_q    <= 1'b0;
      pcq_rd_q    <= 1'b0;
      buf_q       <= '{default: '0};
      buf_wr_q    <= 1'b0;
      buf_rd_q    <= 1'b0;
      buf_cnt_q   <= '0;
      out_q       <= '{ins: NOP, epc: RESET_PC, flt: 1'b0, cause: 4'd0};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      outst_q     <= outst_d;
      stale_q     <= stale_d;
      pcq_q       <= pcq_d;
      pcq_wr_q    <= pcq_wr_d;
      pcq_rd_q    <= pcq_rd_d;
      buf_q       <= buf_d;
      buf_wr_q    <= buf_wr_d;
      buf_rd_q    <= buf_rd_d;
      buf_cnt_q   <= buf_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: table-driven boot/stall stream plus redirect, fault and reset
// sequences, with a scoreboard of expected decode entries.
module tb_ifetch;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [63:0] RST = 64'h1000;

  logic        clk = 1'b0;
  logic        resetn, stall, redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid, imem_resp_fault;
  logic [31:0] imem_resp_data;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        instr_valid, fetch_fault;
  logic [3:0]  fault_cause;

  always #5 clk = ~clk;

  ifetch #(.XLEN(64), .RESET_PC(RST), .NOP(NOP)) dut (
    .clk(clk), .resetn(resetn), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_fault(imem_resp_fault),
    .instr(instr), .pc(pc), .instr_valid(instr_valid),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );

  typedef struct { logic [63:0] pc; logic [31:0] ins; logic flt; logic [3:0] cause; } exp_t;
  typedef struct { logic stall; logic req_v; logic iv; logic [63:0] pc; } vec_t;

  exp_t        sbq[$];
  vec_t        vt[12];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic        fault_en = 1'b0;
  logic [63:0] fault_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t ent(input logic [63:0] p);
    ent.pc = p; ent.ins = p[31:0]; ent.flt = 1'b0; ent.cause = 4'd0;
  endfunction

  function automatic exp_t fent(input logic [63:0] p, input logic [3:0] c);
    fent.pc = p; fent.ins = NOP; fent.flt = 1'b1; fent.cause = c;
  endfunction

  // One clock: memory answers every accepted request exactly one cycle later with
  // mem[a] = a; any newly loaded decode entry is checked against the scoreboard.
  task automatic step();
    logic        acc, ld;
    logic [63:0] a;
    exp_t        e;
    acc = resetn && imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    ld  = resetn && (!stall || redirect_valid);
    @(posedge clk);
    #1;
    imem_resp_valid = acc;
    imem_resp_data  = acc ? a[31:0] : 32'h0;
    imem_resp_fault = acc && fault_en && (a == fault_addr);
    if (ld && instr_valid) begin
      if (sbq.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_unexpected: got pc 0x%0h, expected no entry", pc);
      end else begin
        e = sbq.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_instr", 64'(instr), 64'(e.ins));
        chk("sb_fault", 64'(fetch_fault), 64'(e.flt));
        chk("sb_cause", 64'(fault_cause), 64'(e.cause));
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_req_addr"}, imem_req_addr, RST);
    chk({tag, "_instr"}, 64'(instr), 64'(NOP));
    chk({tag, "_pc"}, pc, RST);
    chk({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, "_fetch_fault"}, 64'(fetch_fault), 64'd0);
    chk({tag, "_fault_cause"}, 64'(fault_cause), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ei;
    // rows: {stall, expected req_valid, expected instr_valid, expected pc}
    vt[0]  = '{1'b0, 1'b0, 1'b0, 64'h1000};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 64'h1000};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 64'h1000};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 64'h1000};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 64'h1004};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 64'h1008};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 64'h1008};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 64'h1008};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 64'h1008};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 64'h100C};
    vt[10] = '{1'b0, 1'b1, 1'b1, 64'h1010};
    vt[11] = '{1'b0, 1'b1, 1'b1, 64'h1014};

    resetn = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_fault = 1'b0;
    repeat (3) step();
    chk_reset("rst");

    // Boot and streaming with a 3-cycle stall
    for (int i = 0; i < 7; i++) sbq.push_back(ent(RST + 64'(4 * i)));
    resetn = 1'b1;
    for (int r = 0; r < 12; r++) begin
      stall = vt[r].stall;
      ei = vt[r].iv ? vt[r].pc[31:0] : NOP;
      chk($sformatf("vec%0d_req_valid", r), 64'(imem_req_valid), 64'(vt[r].req_v));
      chk($sformatf("vec%0d_instr_valid", r), 64'(instr_valid), 64'(vt[r].iv));
      chk($sformatf("vec%0d_pc", r), pc, vt[r].pc);
      chk($sformatf("vec%0d_instr", r), 64'(instr), 64'(ei));
      step();
    end
    stall = 1'b0;
    chk("stream_sb_empty", 64'(sbq.size()), 64'd0);

    // Redirect to 0x2000 while two older fetches are still in flight
    sbq.push_back(ent(64'h2000));
    sbq.push_back(ent(64'h2004));
    redirect_pc = 64'h2000; redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("redir_n1_valid", 64'(instr_valid), 64'd0);
    chk("redir_n1_req_valid", 64'(imem_req_valid), 64'd1);
    chk("redir_n1_req_addr", imem_req_addr, 64'h2000);
    step();
    chk("redir_n1b_valid", 64'(instr_valid), 64'd0);
    step();
    chk("redir_n2_valid", 64'(instr_valid), 64'd1);
    chk("redir_n2_pc", pc, 64'h2000);
    step();

    // Misaligned redirect: a single fault entry, then fetch stays parked
    sbq.push_back(fent(64'h2002, 4'd0));
    redirect_pc = 64'h2002; redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("mis_req_valid0", 64'(imem_req_valid), 64'd0);
    chk("mis_bubble", 64'(instr_valid), 64'd0);
    step();
    chk("mis_fetch_fault", 64'(fetch_fault), 64'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mis_idle%0d_req_valid", k), 64'(imem_req_valid), 64'd0);
    end
    chk("mis_sb_empty", 64'(sbq.size()), 64'd0);
    sbq.push_back(ent(64'h3000));
    redirect_pc = 64'h3000; redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("resume_req_valid", 64'(imem_req_valid), 64'd1);
    chk("resume_req_addr", imem_req_addr, 64'h3000);
    step();
    step();
    chk("resume_pc", pc, 64'h3000);
    chk("resume_sb_empty", 64'(sbq.size()), 64'd0);

    // Reset while a response is pending
    chk("pend_resp_valid", 64'(imem_resp_valid), 64'd1);
    resetn = 1'b0;
    step();
    chk_reset("midrst");
    step();

    // Access fault on the 0x1004 fetch; 0x1008 must be discarded
    fault_en = 1'b1; fault_addr = 64'h1004;
    sbq.push_back(ent(64'h1000));
    sbq.push_back(fent(64'h1004, 4'd1));
    resetn = 1'b1;
    chk("af_boot_req_valid", 64'(imem_req_valid), 64'd0);
    repeat (4) step();
    chk("af_instr", 64'(instr), 64'(NOP));
    chk("af_cause", 64'(fault_cause), 64'd1);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("af_idle%0d_req_valid", k), 64'(imem_req_valid), 64'd0);
      chk($sformatf("af_idle%0d_valid", k), 64'(instr_valid), 64'd0);
    end
    chk("af_sb_empty", 64'(sbq.size()), 64'd0);
    fault_en = 1'b0;

    // Back-pressure: address must hold while ready is low
    sbq.push_back(ent(64'h4000));
    imem_req_ready = 1'b0;
    redirect_pc = 64'h4000; redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d_req_valid", k), 64'(imem_req_valid), 64'd1);
      chk($sformatf("bp%0d_req_addr", k), imem_req_addr, 64'h4000);
      step();
    end
    imem_req_ready = 1'b1;
    chk("bp_final_addr", imem_req_addr, 64'h4000);
    step();
    step();
    chk("bp_sb_empty", 64'(sbq.size()), 64'd0);
    chk("bp_pend_resp", 64'(imem_resp_valid), 64'd1);
    resetn = 1'b0;
    step();
    chk_reset("rst2");
    resetn = 1'b1;
    chk("reboot_req_valid0", 64'(imem_req_valid), 64'd0);
    step();
    chk("reboot_req_valid1", 64'(imem_req_valid), 64'd1);
    chk("reboot_req_addr", imem_req_addr, RST);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
